// File: rtl/wb_arbiter_if.sv
// Bundle of writeback requester, scoreboard and register-file write signals
// shared between the writeback arbiter and its surrounding pipeline.
interface wb_arbiter_if;
    logic        alu_valid;
    logic        alu_fmode;
    logic [4:0]  alu_reg;
    logic [31:0] alu_data;
    logic        alu_ready;

    logic        fpu_valid;
    logic        fpu_fmode;
    logic [4:0]  fpu_reg;
    logic [31:0] fpu_data;
    logic        fpu_ready;

    logic        mem_valid;
    logic        mem_fmode;
    logic [4:0]  mem_reg;
    logic [31:0] mem_data;
    logic        mem_ready;

    logic        claim_en;
    logic        claim_fmode;
    logic [4:0]  claim_reg;

    logic        q1_fmode;
    logic [4:0]  q1_reg;
    logic        q1_busy;
    logic        q2_fmode;
    logic [4:0]  q2_reg;
    logic        q2_busy;

    logic        wenable;
    logic        wfmode;
    logic [4:0]  wreg;
    logic [31:0] wdata;

    // Arbiter side
    modport slave (
        input  alu_valid, alu_fmode, alu_reg, alu_data,
        input  fpu_valid, fpu_fmode, fpu_reg, fpu_data,
        input  mem_valid, mem_fmode, mem_reg, mem_data,
        input  claim_en, claim_fmode, claim_reg,
        input  q1_fmode, q1_reg, q2_fmode, q2_reg,
        output alu_ready, fpu_ready, mem_ready,
        output q1_busy, q2_busy,
        output wenable, wfmode, wreg, wdata
    );

    // Pipeline / requester side
    modport master (
        output alu_valid, alu_fmode, alu_reg, alu_data,
        output fpu_valid, fpu_fmode, fpu_reg, fpu_data,
        output mem_valid, mem_fmode, mem_reg, mem_data,
        output claim_en, claim_fmode, claim_reg,
        output q1_fmode, q1_reg, q2_fmode, q2_reg,
        input  alu_ready, fpu_ready, mem_ready,
        input  q1_busy, q2_busy,
        input  wenable, wfmode, wreg, wdata
    );
endinterface

// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing one register-file write port among ALU, FPU and
// MEM writebacks, with a 64-entry pending-write scoreboard for issue hazards.
module wb_arbiter (
    input  logic        clk,
    input  logic        rstn,
    wb_arbiter_if.slave bus
);

    // Next round-robin start after a grant to idx.
    function automatic logic [1:0] inc_mod3(input logic [1:0] idx);
        logic [1:0] res;
        case (idx)
            2'd0:    res = 2'd1;
            2'd1:    res = 2'd2;
            default: res = 2'd0;
        endcase
        return res;
    endfunction

    // Scoreboard lookup; integer r0 is hardwired and never pending.
    function automatic logic pend_lookup(input logic [63:0] pend,
                                         input logic        fmode,
                                         input logic [4:0]  rnum);
        logic res;
        if (!fmode && (rnum == 5'd0)) begin
            res = 1'b0;
        end else begin
            res = pend[{fmode, rnum}];
        end
        return res;
    endfunction

    logic [1:0]  ptr_r;
    logic [1:0]  ptr_eff_s;
    logic [2:0]  valid_s;
    logic [1:0]  ord0_s, ord1_s, ord2_s;
    logic [1:0]  gidx_s;
    logic        found_s;
    logic [2:0]  grant_s;
    logic        xfer_s;
    logic        pay_fmode_s;
    logic [4:0]  pay_reg_s;
    logic [31:0] pay_data_s;
    logic        pay_zero_s;
    logic [1:0]  ptr_next_s;
    logic [63:0] pend_r;
    logic [63:0] pend_next_s;
    logic        wenable_r;
    logic        wfmode_r;
    logic [4:0]  wreg_r;
    logic [31:0] wdata_r;

    assign valid_s   = {bus.mem_valid, bus.fpu_valid, bus.alu_valid};
    // An illegal pointer value of 3 behaves as 0 until it is reloaded.
    assign ptr_eff_s = (ptr_r == 2'd3) ? 2'd0 : ptr_r;

    // Search order starting from the round-robin pointer.
    always_comb begin
        ord0_s = 2'd0;
        ord1_s = 2'd1;
        ord2_s = 2'd2;
        case (ptr_eff_s)
            2'd0: begin
                ord0_s = 2'd0; ord1_s = 2'd1; ord2_s = 2'd2;
            end
            2'd1: begin
                ord0_s = 2'd1; ord1_s = 2'd2; ord2_s = 2'd0;
            end
            default: begin
                ord0_s = 2'd2; ord1_s = 2'd0; ord2_s = 2'd1;
            end
        endcase
    end

    // First valid requester in search order wins; nothing is granted in reset.
    always_comb begin
        gidx_s  = 2'd0;
        found_s = 1'b0;
        if (valid_s[ord0_s]) begin
            gidx_s  = ord0_s;
            found_s = 1'b1;
        end else if (valid_s[ord1_s]) begin
            gidx_s  = ord1_s;
            found_s = 1'b1;
        end else if (valid_s[ord2_s]) begin
            gidx_s  = ord2_s;
            found_s = 1'b1;
        end else begin
            gidx_s  = 2'd0;
            found_s = 1'b0;
        end
    end

    assign xfer_s  = found_s & ~rstn;
    assign grant_s = xfer_s ? (3'b001 << gidx_s) : 3'b000;

    assign bus.alu_ready = grant_s[0];
    assign bus.fpu_ready = grant_s[1];
    assign bus.mem_ready = grant_s[2];

    // Payload of the granted requester.
    always_comb begin
        pay_fmode_s = 1'b0;
        pay_reg_s   = 5'd0;
        pay_data_s  = 32'd0;
        case (gidx_s)
            2'd0: begin
                pay_fmode_s = bus.alu_fmode;
                pay_reg_s   = bus.alu_reg;
                pay_data_s  = bus.alu_data;
            end
            2'd1: begin
                pay_fmode_s = bus.fpu_fmode;
                pay_reg_s   = bus.fpu_reg;
                pay_data_s  = bus.fpu_data;
            end
            2'd2: begin
                pay_fmode_s = bus.mem_fmode;
                pay_reg_s   = bus.mem_reg;
                pay_data_s  = bus.mem_data;
            end
            default: begin
                pay_fmode_s = 1'b0;
                pay_reg_s   = 5'd0;
                pay_data_s  = 32'd0;
            end
        endcase
    end

    assign pay_zero_s = ~pay_fmode_s & (pay_reg_s == 5'd0);

    // Pointer advance: past the winner on a transfer, otherwise sanitised hold.
    always_comb begin
        ptr_next_s = ptr_eff_s;
        if (xfer_s) begin
            ptr_next_s = inc_mod3(gidx_s);
        end else begin
            ptr_next_s = ptr_eff_s;
        end
    end

    // Scoreboard update: the transfer clears first so a same-edge claim wins.
    always_comb begin
        pend_next_s = pend_r;
        if (xfer_s) begin
            pend_next_s[{pay_fmode_s, pay_reg_s}] = 1'b0;
        end else begin
            pend_next_s = pend_r;
        end
        if (bus.claim_en && (bus.claim_fmode || (bus.claim_reg != 5'd0))) begin
            pend_next_s[{bus.claim_fmode, bus.claim_reg}] = 1'b1;
        end else begin
            pend_next_s[0] = 1'b0;
        end
    end

    // Arbitration pointer and scoreboard state.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            ptr_r  <= 2'd0;
            pend_r <= 64'd0;
        end else begin
            ptr_r  <= ptr_next_s;
            pend_r <= pend_next_s;
        end
    end

    // Registered register-file write port; payload holds when idle.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            wenable_r <= 1'b0;
            wfmode_r  <= 1'b0;
            wreg_r    <= 5'd0;
            wdata_r   <= 32'd0;
        end else begin
            wenable_r <= xfer_s & ~pay_zero_s;
            if (xfer_s) begin
                wfmode_r <= pay_fmode_s;
                wreg_r   <= pay_reg_s;
                wdata_r  <= pay_data_s;
            end
        end
    end

    assign bus.wenable = wenable_r;
    assign bus.wfmode  = wfmode_r;
    assign bus.wreg    = wreg_r;
    assign bus.wdata   = wdata_r;

    assign bus.q1_busy = pend_lookup(pend_r, bus.q1_fmode, bus.q1_reg);
    assign bus.q2_busy = pend_lookup(pend_r, bus.q2_fmode, bus.q2_reg);

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed and randomized checks of wb_arbiter against a round-robin and
// scoreboard reference model kept in the bench.
module tb_wb_arbiter;
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    wb_arbiter_if bus ();
    wb_arbiter dut (.clk(clk), .rstn(rstn), .bus(bus));

    int total = 0;
    int bad   = 0;

    bit        v[3];
    bit        fm[3];
    bit [4:0]  rg[3];
    bit [31:0] dt[3];
    bit        c_en, c_f;
    bit [4:0]  c_r;
    bit        q1f, q2f;
    bit [4:0]  q1r, q2r;

    bit        pend[2][32];
    int        m_ptr;
    bit        e_we, e_f;
    bit [4:0]  e_r;
    bit [31:0] e_d;
    int        last_g;
    int        exp_order[4] = '{0, 1, 2, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        bus.alu_valid = v[0]; bus.alu_fmode = fm[0]; bus.alu_reg = rg[0]; bus.alu_data = dt[0];
        bus.fpu_valid = v[1]; bus.fpu_fmode = fm[1]; bus.fpu_reg = rg[1]; bus.fpu_data = dt[1];
        bus.mem_valid = v[2]; bus.mem_fmode = fm[2]; bus.mem_reg = rg[2]; bus.mem_data = dt[2];
        bus.claim_en = c_en; bus.claim_fmode = c_f; bus.claim_reg = c_r;
        bus.q1_fmode = q1f; bus.q1_reg = q1r; bus.q2_fmode = q2f; bus.q2_reg = q2r;
    endtask

    function automatic bit m_busy(input bit f, input bit [4:0] r);
        return (!f && r == 5'd0) ? 1'b0 : pend[f][r];
    endfunction

    task automatic model_reset();
        for (int f = 0; f < 2; f++)
            for (int r = 0; r < 32; r++) pend[f][r] = 1'b0;
        m_ptr = 0; e_we = 1'b0; e_f = 1'b0; e_r = 5'd0; e_d = 32'd0;
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 3; i++) begin
            v[i] = 1'b0; fm[i] = 1'b0; rg[i] = 5'd0; dt[i] = 32'd0;
        end
        c_en = 1'b0; c_f = 1'b0; c_r = 5'd0;
        q1f = 1'b0; q1r = 5'd0; q2f = 1'b0; q2r = 5'd0;
    endtask

    // One clock cycle: drive, check grant, take the edge, check registered results.
    task automatic step();
        int g;
        g = -1;
        drive();
        #1;
        for (int k = 0; k < 3; k++)
            if (g < 0 && v[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
        chk("alu_ready", bus.alu_ready, g == 0);
        chk("fpu_ready", bus.fpu_ready, g == 1);
        chk("mem_ready", bus.mem_ready, g == 2);
        @(posedge clk);
        e_we = 1'b0;
        if (g >= 0) begin
            e_we = fm[g] || (rg[g] != 5'd0);
            e_f  = fm[g]; e_r = rg[g]; e_d = dt[g];
            pend[fm[g]][rg[g]] = 1'b0;
            m_ptr = (g + 1) % 3;
            v[g]  = 1'b0;
        end
        if (c_en && (c_f || c_r != 5'd0)) pend[c_f][c_r] = 1'b1;
        c_en   = 1'b0;
        last_g = g;
        #1;
        chk("wenable", bus.wenable, e_we);
        chk("wfmode",  bus.wfmode,  e_f);
        chk("wreg",    bus.wreg,    e_r);
        chk("wdata",   bus.wdata,   e_d);
        chk("q1_busy", bus.q1_busy, m_busy(q1f, q1r));
        chk("q2_busy", bus.q2_busy, m_busy(q2f, q2r));
    endtask

    task automatic do_reset();
        rstn = 1'b1;
        clear_inputs();
        drive();
        model_reset();
        #1;
        chk("rst_wenable", bus.wenable, 1'b0);
        chk("rst_wdata",   bus.wdata,   32'd0);
        chk("rst_wreg",    bus.wreg,    5'd0);
        @(posedge clk);
        #1;
        rstn = 1'b0;
    endtask

    initial begin
        clear_inputs();
        model_reset();
        do_reset();

        // Single ALU write
        v[0] = 1'b1; rg[0] = 5'd5; dt[0] = 32'h0000_00AA;
        step();
        chk("single_we",   bus.wenable, 1'b1);
        chk("single_reg",  bus.wreg,    5'd5);
        chk("single_data", bus.wdata,   32'h0000_00AA);
        step();
        chk("single_idle", bus.wenable, 1'b0);

        // Contention from reset
        do_reset();
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 3; j++) begin
                if (!v[j]) begin
                    v[j] = 1'b1; fm[j] = (j == 1); rg[j] = 5'(10 + j); dt[j] = $urandom;
                end
            end
            step();
            chk("grant_order", last_g, exp_order[i]);
            chk("contend_we", bus.wenable, 1'b1);
        end
        clear_inputs();
        step();

        // Scoreboard claim and clear via MEM
        c_en = 1'b1; c_f = 1'b0; c_r = 5'd7;
        q1f = 1'b0; q1r = 5'd7; q2f = 1'b1; q2r = 5'd7;
        step();
        chk("r7_claimed", bus.q1_busy, 1'b1);
        chk("f7_idle",    bus.q2_busy, 1'b0);
        v[2] = 1'b1; fm[2] = 1'b0; rg[2] = 5'd7; dt[2] = 32'h1234_5678;
        step();
        chk("r7_write",   bus.wenable, 1'b1);
        chk("r7_cleared", bus.q1_busy, 1'b0);
        chk("f7_still",   bus.q2_busy, 1'b0);

        // Claim/clear collision on f3
        q2f = 1'b1; q2r = 5'd3;
        c_en = 1'b1; c_f = 1'b1; c_r = 5'd3;
        v[1] = 1'b1; fm[1] = 1'b1; rg[1] = 5'd3; dt[1] = 32'hF3F3_0003;
        step();
        chk("f3_claim_wins", bus.q2_busy, 1'b1);

        // Integer r0 write and claim
        q1f = 1'b0; q1r = 5'd0;
        c_en = 1'b1; c_f = 1'b0; c_r = 5'd0;
        v[0] = 1'b1; fm[0] = 1'b0; rg[0] = 5'd0; dt[0] = 32'hDEAD_BEEF;
        step();
        chk("r0_no_write", bus.wenable, 1'b0);
        chk("r0_not_busy", bus.q1_busy, 1'b0);

        // Float f0 is an ordinary register
        v[0] = 1'b1; fm[0] = 1'b1; rg[0] = 5'd0; dt[0] = 32'h0F0F_0F0F;
        step();
        chk("f0_write", bus.wenable, 1'b1);

        // Reset in mid-cycle during an FPU request
        c_en = 1'b1; c_f = 1'b0; c_r = 5'd9; q1f = 1'b0; q1r = 5'd9;
        step();
        chk("r9_claimed", bus.q1_busy, 1'b1);
        v[1] = 1'b1; fm[1] = 1'b0; rg[1] = 5'd9; dt[1] = 32'h9999_9999;
        drive();
        #2;
        rstn = 1'b1;
        #1;
        chk("mid_rst_we",    bus.wenable,   1'b0);
        chk("mid_rst_data",  bus.wdata,     32'd0);
        chk("mid_rst_ready", bus.fpu_ready, 1'b0);
        chk("mid_rst_busy",  bus.q1_busy,   1'b0);
        model_reset();
        v[1] = 1'b0;
        drive();
        @(posedge clk);
        #1;
        rstn = 1'b0;
        step();
        chk("post_rst_we", bus.wenable, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            for (int j = 0; j < 3; j++) begin
                if (!v[j] && $urandom_range(0, 2) != 0) begin
                    v[j] = 1'b1; fm[j] = 1'($urandom); rg[j] = 5'($urandom_range(0, 7));
                    dt[j] = $urandom;
                end
            end
            c_en = ($urandom_range(0, 2) == 0);
            c_f  = 1'($urandom); c_r = 5'($urandom_range(0, 7));
            q1f  = 1'($urandom); q1r = 5'($urandom_range(0, 7));
            q2f  = 1'($urandom); q2r = 5'($urandom_range(0, 7));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have: rstn  in  1  asynchronous active-high reset (asserted = 1).
REQ-003 SHALL have, per requester X in {alu, fpu, mem}: X_valid in 1, X_fmode in 1 (1 = float file), X_reg in 5, X_data in 32, X_ready out 1.
REQ-004 SHALL have: claim_en in 1, claim_fmode in 1, claim_reg in 5  issue-side scoreboard claim.
REQ-005 SHALL have: q1_fmode in 1, q1_reg in 5, q1_busy out 1; q2_fmode in 1, q2_reg in 5, q2_busy out 1  scoreboard queries.
REQ-006 SHALL have: wenable out 1, wfmode out 1, wreg out 5, wdata out 32  register-file write port.

Function
REQ-007 SHALL share the single register-file write port among ALU (index 0), FPU (1) and MEM (2) writeback requesters.
REQ-008 SHALL grant at most one requester per cycle; X_ready is combinational and high only for the granted requester.
REQ-009 SHALL treat X_valid & X_ready at a rising edge as one transfer; requesters hold valid and payload stable until ready.
REQ-010 SHALL arbitrate round-robin: 2-bit pointer P in {0,1,2}; search order P, P+1, P+2 (mod 3); first valid requester wins.
REQ-011 SHALL set P to (granted index + 1) mod 3 after every transfer; P unchanged when no transfer.
REQ-012 SHALL never hold P = 3; if reached, SHALL treat it as 0 and load 0 next edge.
REQ-013 SHALL register the granted payload: wenable/wfmode/wreg/wdata reflect the transfer on the cycle after the edge on which it occurs (latency 1).
REQ-014 SHALL drive wenable = 0 in any cycle following an edge with no transfer; wfmode/wreg/wdata then hold previous values.
REQ-015 SHALL accept but suppress writes to integer register 0 (fmode = 0, reg = 0): transfer completes, wenable stays 0.
REQ-016 SHALL treat float register 0 as an ordinary writable register.
REQ-017 SHALL keep a 64-bit pending scoreboard: bit {fmode, reg}; bit set on claim_en at an edge.
REQ-018 SHALL ignore claims of integer register 0 (bit never set).
REQ-019 SHALL clear the pending bit of {X_fmode, X_reg} at the edge on which the transfer occurs.
REQ-020 SHALL, on claim and transfer-clear of the same register at the same edge, leave the bit set (claim wins).
REQ-021 SHALL leave a bit set when claiming an already-pending register; the next transfer to it clears it.
REQ-022 SHALL drive qN_busy combinationally from the pending bit {qN_fmode, qN_reg}; no bypass of same-cycle claims or transfers.
REQ-023 SHALL report integer register 0 as never busy.
REQ-024 SHALL allow transfers to unclaimed registers; the write proceeds and the scoreboard is unaffected.

Reset
REQ-025 SHALL, while rstn = 1, force wenable = 0, wfmode = 0, wreg = 0, wdata = 0, P = 0, all 64 pending bits = 0, independent of clk.
REQ-026 SHALL drive all X_ready = 0 while rstn = 1.
REQ-027 SHALL discard a transfer coinciding with reset assertion; no write issues after reset release.
REQ-028 SHALL resume arbitration at the first rising edge after rstn deasserts, ALU at highest priority.

Verification
REQ-029 Single: after reset, alu_valid=1, reg 5, data 0x0000_00AA -> alu_ready=1 same cycle; next cycle wenable=1, wfmode=0, wreg=5, wdata=0xAA; then wenable=0.
REQ-030 Contention: all three valid continuously from reset -> grant order ALU, FPU, MEM, ALU; wenable high every cycle, one write each.
REQ-031 Scoreboard: claim int r7 -> q1(0,7) busy=1 next cycle; MEM write r7 -> busy=0 the cycle wenable=1; f7 never busy throughout.
REQ-032 Collision: claim f3 on the same edge as FPU transfer to f3 -> q2(1,3) busy=1 afterwards.
REQ-033 Zero register: ALU write int r0 with claim r0 -> alu_ready=1, wenable stays 0, q1(0,0) busy=0.
REQ-034 Reset mid-operation: claim r9, assert rstn mid-cycle with fpu_valid=1 -> outputs 0 immediately, r9 not busy, no write after release.
